// File: rtl/fft_pkg.sv
// Shared FFT constants and the bit-reverse helper used to reorder SDF output frames.
package fft_pkg;

  localparam int unsigned MAX_LOG_N = 10;

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_e;

  // Reverses the low nbits of v; bits at and above nbits come back zero.
  function automatic logic [MAX_LOG_N-1:0] bitrev(input logic [MAX_LOG_N-1:0] v,
                                                  input int unsigned nbits);
    logic [MAX_LOG_N-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < MAX_LOG_N; b++) begin
      for (int unsigned s = 0; s < MAX_LOG_N; s++) begin
        if ((b < nbits) && (s == nbits - 1 - b)) r[b] = v[s];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_ram.sv
// Dual-port complex-word RAM: synchronous write, one-cycle registered read that holds when idle.
module reorder_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 7
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [2*WIDTH-1:0]   wdata_i,
  input  logic                 re_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [2*WIDTH-1:0]   rdata_o
);

  logic [2*WIDTH-1:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder of bit-reversed SDF FFT output into natural order, latency 2 after the last word.
// Optional macro FFT_REORDER_XCHECK_EN drives X on odata_r/odata_i whenever odata_en is low.
module fft_output_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LOG_N = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             idata_en,
  input  logic [WIDTH-1:0] idata_r,
  input  logic [WIDTH-1:0] idata_i,
  output logic             odata_en,
  output logic [WIDTH-1:0] odata_r,
  output logic [WIDTH-1:0] odata_i,
  output logic             oframe_start
);

  localparam logic [LOG_N-1:0] LAST = '1;

  logic [LOG_N-1:0]   wcnt_q, wcnt_d;
  logic [LOG_N-1:0]   rd_cnt_q, rd_cnt_d;
  bank_e              wbank_q, wbank_d;
  bank_e              rbank_q, rbank_d;
  logic               rd_active_q, rd_active_d;
  logic               oen_q, ofs_q;
  logic               frame_done;
  logic [LOG_N-1:0]   wr_slot;
  logic [2*WIDTH-1:0] rdata;

  assign frame_done = idata_en && (wcnt_q == LAST);
  assign wr_slot    = LOG_N'(bitrev(MAX_LOG_N'(wcnt_q), LOG_N));

  always_comb begin
    wcnt_d      = wcnt_q;
    rd_cnt_d    = rd_cnt_q;
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    rd_active_d = rd_active_q;
    if (idata_en) wcnt_d = wcnt_q + 1'b1;
    if (rd_active_q) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
      if (rd_cnt_q == LAST) rd_active_d = 1'b0;
    end
    // A completed fill wins over the end of the previous read so back-to-back bursts have no gap.
    if (frame_done) begin
      wbank_d     = (wbank_q == BANK_0) ? BANK_1 : BANK_0;
      rbank_d     = wbank_q;
      rd_active_d = 1'b1;
      rd_cnt_d    = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wcnt_q      <= '0;
      rd_cnt_q    <= '0;
      wbank_q     <= BANK_0;
      rbank_q     <= BANK_0;
      rd_active_q <= 1'b0;
      oen_q       <= 1'b0;
      ofs_q       <= 1'b0;
    end else begin
      wcnt_q      <= wcnt_d;
      rd_cnt_q    <= rd_cnt_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      rd_active_q <= rd_active_d;
      oen_q       <= rd_active_q;
      ofs_q       <= rd_active_q && (rd_cnt_q == '0);
    end
  end

  reorder_ram #(
    .WIDTH (WIDTH),
    .AW    (LOG_N + 1)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (idata_en),
    .waddr_i ({wbank_q, wr_slot}),
    .wdata_i ({idata_r, idata_i}),
    .re_i    (rd_active_q),
    .raddr_i ({rbank_q, rd_cnt_q}),
    .rdata_o (rdata)
  );

  assign odata_en     = oen_q;
  assign oframe_start = ofs_q;

`ifdef FFT_REORDER_XCHECK_EN
  assign odata_r = oen_q ? rdata[2*WIDTH-1:WIDTH] : 'x;
  assign odata_i = oen_q ? rdata[WIDTH-1:0]       : 'x;
`else
  assign odata_r = rdata[2*WIDTH-1:WIDTH];
  assign odata_i = rdata[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench for fft_output_reorder (WIDTH=16, LOG_N=6): contiguous, back-to-back, gapped and reset frames.
`timescale 1ns/1ps
module tb_fft_output_reorder;

  localparam int WIDTH = 16;
  localparam int LOG_N = 6;
  localparam int N     = 64;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] i;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             idata_en = 1'b0;
  logic [WIDTH-1:0] idata_r = '0;
  logic [WIDTH-1:0] idata_i = '0;
  logic             odata_en;
  logic             oframe_start;
  logic [WIDTH-1:0] odata_r;
  logic [WIDTH-1:0] odata_i;

  exp_t sb[$];
  int   starts[$];
  int   cyc    = 0;
  int   remain = 0;
  int   errors = 0;
  int   checks = 0;

  fft_output_reorder #(
    .WIDTH (WIDTH),
    .LOG_N (LOG_N)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .idata_en     (idata_en),
    .idata_r      (idata_r),
    .idata_i      (idata_i),
    .odata_en     (odata_en),
    .odata_r      (odata_r),
    .odata_i      (odata_i),
    .oframe_start (oframe_start)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int br6(input int j);
    int r;
    r = 0;
    for (int b = 0; b < LOG_N; b++) r = r | (((j >> (LOG_N - 1 - b)) & 1) << b);
    return r;
  endfunction

  // Drives count words of a frame with values base+k / -(base+k); a finished frame books its expected burst.
  task automatic drive_frame(input int base, input bit gap, input int count);
    for (int k = 0; k < count; k++) begin
      @(posedge clock); #1;
      idata_en = 1'b1;
      idata_r  = WIDTH'(base + k);
      idata_i  = WIDTH'(-(base + k));
      if (k == N - 1) begin
        for (int j = 0; j < N; j++) begin
          exp_t e;
          e.r = WIDTH'(base + br6(j));
          e.i = WIDTH'(-(base + br6(j)));
          sb.push_back(e);
        end
        starts.push_back(cyc + 2);
        $display("frame base=%0d last word at cycle %0d, burst expected at %0d", base, cyc, cyc + 2);
      end
      if (gap) begin
        @(posedge clock); #1;
        idata_en = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clock); #1;
    idata_en = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: every cycle checks odata_en/oframe_start against the booked bursts, and data while valid.
  initial begin
    logic exp_en;
    logic exp_fs;
    exp_t e;
    forever begin
      @(negedge clock);
      exp_en = (remain > 0) || ((starts.size() > 0) && (starts[0] == cyc));
      exp_fs = exp_en && (remain == 0);
      check_eq("odata_en", 32'(odata_en), 32'(exp_en));
      check_eq("oframe_start", 32'(oframe_start), 32'(exp_fs));
      if (exp_en) begin
        if (remain == 0) begin
          void'(starts.pop_front());
          remain = N;
        end
        remain--;
        e = sb.pop_front();
        if (odata_en) begin
          check_eq("odata_r", 32'(odata_r), 32'(e.r));
          check_eq("odata_i", 32'(odata_i), 32'(e.i));
          if (exp_fs) $display("burst start at cycle %0d: odata_r=%0d odata_i=%h", cyc, odata_r, odata_i);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    check_eq("rst_odata_en", 32'(odata_en), 32'd0);
    check_eq("rst_oframe_start", 32'(oframe_start), 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;

    // Contiguous frame, then hold/X behaviour of the idle output.
    drive_frame(0, 1'b0, N);
    idle(70);
`ifdef FFT_REORDER_XCHECK_EN
    check_eq("idle_odata_r", 32'(odata_r), {16'h0, 16'hxxxx});
    check_eq("idle_odata_i", 32'(odata_i), {16'h0, 16'hxxxx});
`else
    check_eq("hold_odata_r", 32'(odata_r), 32'd63);
    check_eq("hold_odata_i", 32'(odata_i), 32'h0000ffc1);
`endif

    // Back-to-back frames: 128 continuous valid cycles.
    drive_frame(0, 1'b0, N);
    drive_frame(64, 1'b0, N);
    idle(140);

    // Input valid every other cycle.
    drive_frame(0, 1'b1, N);
    idle(70);

    // Reset mid-frame after 30 words, then a fresh frame.
    drive_frame(100, 1'b0, 30);
    @(posedge clock); #1;
    idata_en = 1'b0;
    reset    = 1'b0;
    #1;
    check_eq("midrst_odata_en", 32'(odata_en), 32'd0);
    check_eq("midrst_oframe_start", 32'(oframe_start), 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    drive_frame(0, 1'b0, N);
    idle(70);

    for (int w = 0; (w < 200) && (sb.size() > 0); w++) @(posedge clock);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    check_eq("starts_drain", 32'(starts.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_output_reorder.md
FFT_OUTPUT_REORDER -- requirements
Module: fft_output_reorder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data bit length per real/imag component.
REQ-002 SHALL have parameter LOG_N, default 6: log2 of FFT point count N (N = 2**LOG_N; legal 2..10).
REQ-003 SHALL have port clock  input  1  master clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port idata_en  input  1  input word valid, from the last SDF stage, in bit-reversed frame order.
REQ-006 SHALL have ports idata_r / idata_i  input  WIDTH  input data real / imag.
REQ-007 SHALL have port odata_en  output  1  output word valid, natural frame order.
REQ-008 SHALL have ports odata_r / odata_i  output  WIDTH  output data real / imag, registered.
REQ-009 SHALL have port oframe_start  output  1  high with the first odata_en word (bin 0) of each frame.

Function
REQ-010 SHALL contain two banks of N complex words (ping-pong); one bank written while the other is read.
REQ-011 SHALL keep LOG_N-bit write counter wcnt; each idata_en cycle writes input to write bank at address bitrev(wcnt), then wcnt increments modulo N.
REQ-012 SHALL, when word with wcnt = N-1 is written (cycle t), toggle write bank and start a read of the filled bank at cycle t+1.
REQ-013 SHALL read the filled bank at sequential addresses 0..N-1 on N consecutive cycles, no gaps, independent of idata_en.
REQ-014 SHALL assert odata_en from cycle t+2 through t+N+1 inclusive (latency 2 after the last input word); oframe_start on cycle t+2 only.
REQ-015 SHALL accept idata_en with arbitrary gaps; gaps only delay frame completion, never corrupt order.
REQ-016 SHALL support back-to-back frames (idata_en continuously high) with odata_en continuously high after the first frame; no overflow possible since a read takes exactly N cycles and a fill at least N.
REQ-017 SHALL, when a read ends in the same cycle the next read starts (back-to-back), continue seamlessly from address N-1 of old bank to address 0 of new bank.
REQ-018 SHALL pass data unmodified (no scaling, no rounding, width WIDTH in and out).

Reset
REQ-019 SHALL, on reset low, immediately clear wcnt, read counter, read-active flag, bank select, odata_en, oframe_start.
REQ-020 SHALL not reset memory contents nor odata_r/odata_i (data path registers have no reset).
REQ-021 SHALL discard a partially written or partially read frame on reset mid-operation; first post-reset idata_en word is frame index 0.

Configuration
REQ-022 SHALL honour macro FFT_REORDER_XCHECK_EN: when defined, odata_r/odata_i drive all-X whenever odata_en is low (verification aid); when undefined, they hold the last valid value.
REQ-023 SHALL have identical odata_en/oframe_start timing with and without FFT_REORDER_XCHECK_EN.

Structure
REQ-024 SHALL take a bit-reverse function (parameterised by LOG_N) and frame constants from shared package fft_pkg.
REQ-025 SHALL instantiate sub-module reorder_ram: one synchronous-write, one-cycle registered-read dual-port complex RAM of 2*N words (bank select as address MSB).

Verification (WIDTH=16, LOG_N=6, N=64)
REQ-026 SHALL verify: contiguous frame idata_r=k, idata_i=-k, k=0..63 -> 64-cycle odata_en burst starting 2 cycles after word 63, odata_r[j]=bitrev6(j) (j=0:0, j=1:32, j=2:16, j=63:63), odata_i negated, oframe_start on j=0 only.
REQ-027 SHALL verify: two back-to-back frames (values k, then 64+k) -> odata_en high 128 consecutive cycles, second burst values 64+bitrev6(j), oframe_start twice, 64 cycles apart.
REQ-028 SHALL verify: idata_en asserted every other cycle for one frame -> odata_en stays low until 2 cycles after the 64th word, then one contiguous 64-cycle burst in correct order.
REQ-029 SHALL verify: reset pulsed low after 30 input words, then a full fresh frame -> no odata_en until fresh frame completes; output equals REQ-026 pattern, no stale words.
REQ-030 SHALL verify: after the REQ-026 burst, with FFT_REORDER_XCHECK_EN defined odata_r is X while odata_en low; undefined, odata_r holds 63.
